// File: rtl/tcam_entry_writer.sv
// rtl/tcam_entry_writer.sv - FracTCAM entry programming engine driving per-column LUTRAM match tables
module tcam_entry_writer #(
    parameter int KEY_WIDTH = 30,
    parameter int CHUNK     = 5,
    parameter int DEPTH     = 64,
    localparam int COLS     = (KEY_WIDTH + CHUNK - 1) / CHUNK,
    localparam int ENTRY_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_del,
    input  logic [KEY_WIDTH-1:0] s_key,
    input  logic [KEY_WIDTH-1:0] s_mask,
    input  logic [ENTRY_W-1:0]   s_entry,
    output logic [DEPTH-1:0]     wr_en,
    output logic [CHUNK-1:0]     wr_addr,
    output logic [COLS-1:0]      wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int PAD_W = COLS * CHUNK;
    localparam logic [ENTRY_W:0] DEPTH_V = (ENTRY_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;

    state_t               state, state_d;
    logic [CHUNK-1:0]     cnt, cnt_d;
    logic                 del_q, del_d;
    logic                 err_q, err_flag_d;
    logic [PAD_W-1:0]     key_q, key_d, mask_q, mask_d;
    logic [ENTRY_W-1:0]   entry_q, entry_d;

    logic                 s_ready_d, busy_d, done_d, err_d;
    logic [DEPTH-1:0]     wr_en_d;
    logic [CHUNK-1:0]     wr_addr_d;
    logic [COLS-1:0]      wr_data_d;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        del_d      = del_q;
        key_d      = key_q;
        mask_d     = mask_q;
        entry_d    = entry_q;
        err_flag_d = err_q;
        case (state)
            WRITE: begin
                if (cnt == {CHUNK{1'b1}}) state_d = FIN;
                else                      cnt_d   = cnt + 1'b1;
            end
            default: begin
                state_d = IDLE;
                if (s_valid && s_ready) begin
                    del_d   = s_del;
                    // zero-extended pad bits are key 0 / don't care, so they always match
                    key_d   = PAD_W'(s_key);
                    mask_d  = PAD_W'(s_mask);
                    entry_d = s_entry;
                    cnt_d   = '0;
                    if ({1'b0, s_entry} >= DEPTH_V) begin
                        state_d    = FIN;
                        err_flag_d = 1'b1;
                    end else begin
                        state_d    = WRITE;
                        err_flag_d = 1'b0;
                    end
                end
            end
        endcase

        // Outputs are registered from the next-state view so writes start the cycle after accept.
        s_ready_d = (state_d != WRITE);
        busy_d    = (state_d == WRITE);
        done_d    = (state_d == FIN);
        err_d     = done_d && err_flag_d;
        wr_en_d   = busy_d ? (DEPTH'(1) << entry_d) : '0;
        wr_addr_d = busy_d ? cnt_d : '0;
        for (int c = 0; c < COLS; c++) begin
            wr_data_d[c] = busy_d && !del_d &&
                (((cnt_d ^ key_d[c*CHUNK +: CHUNK]) & mask_d[c*CHUNK +: CHUNK]) == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            del_q   <= 1'b0;
            err_q   <= 1'b0;
            key_q   <= '0;
            mask_q  <= '0;
            entry_q <= '0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            wr_en   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            del_q   <= del_d;
            err_q   <= err_flag_d;
            key_q   <= key_d;
            mask_q  <= mask_d;
            entry_q <= entry_d;
            s_ready <= s_ready_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            wr_en   <= wr_en_d;
            wr_addr <= wr_addr_d;
            wr_data <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_tcam_entry_writer.sv
// tb/tb_tcam_entry_writer.sv - randomized self-checking bench for tcam_entry_writer
module tb_tcam_entry_writer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 10-bit key instance
    logic       v10, rdy10, del10, busy10, done10, err10;
    logic [9:0] key10, mask10;
    logic [2:0] ent10;
    logic [5:0] wen10;
    logic [4:0] waddr10;
    logic [1:0] wdata10;

    // 8-bit key instance (pad bits in the top column)
    logic       v8, rdy8, del8, busy8, done8, err8;
    logic [7:0] key8, mask8;
    logic [2:0] ent8;
    logic [5:0] wen8;
    logic [4:0] waddr8;
    logic [1:0] wdata8;

    tcam_entry_writer #(.KEY_WIDTH(10), .CHUNK(5), .DEPTH(6)) dut10 (
        .clk(clk), .rst_n(rst_n), .s_valid(v10), .s_ready(rdy10), .s_del(del10),
        .s_key(key10), .s_mask(mask10), .s_entry(ent10), .wr_en(wen10),
        .wr_addr(waddr10), .wr_data(wdata10), .busy(busy10), .done(done10), .err(err10)
    );

    tcam_entry_writer #(.KEY_WIDTH(8), .CHUNK(5), .DEPTH(6)) dut8 (
        .clk(clk), .rst_n(rst_n), .s_valid(v8), .s_ready(rdy8), .s_del(del8),
        .s_key(key8), .s_mask(mask8), .s_entry(ent8), .wr_en(wen8),
        .wr_addr(waddr8), .wr_data(wdata8), .busy(busy8), .done(done8), .err(err8)
    );

    // A column bit matches address a unless some real, cared-for key bit disagrees with a.
    function automatic logic [1:0] model_bits(input int kw, input logic d,
                                              input logic [9:0] k, input logic [9:0] m,
                                              input int a);
        logic [1:0] r;
        for (int c = 0; c < 2; c++) begin
            r[c] = !d;
            for (int b = 0; b < 5; b++) begin
                int i;
                i = c * 5 + b;
                if (i < kw && m[i] && (((a >> b) & 1) != int'(k[i]))) r[c] = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic expect_writes10(input logic d, input logic [9:0] k, input logic [9:0] m,
                                   input int e, input int n);
        logic [5:0] exp_en;
        logic [1:0] exp_d;
        exp_en = 6'd1 << e;
        for (int a = 0; a < n; a++) begin
            exp_d = model_bits(10, d, k, m, a);
            checks++;
            if (wen10 !== exp_en) begin
                errors++;
                $display("FAIL wr_en cyc=%0d got=%b exp=%b", a, wen10, exp_en);
            end
            checks++;
            if (waddr10 !== 5'(a)) begin
                errors++;
                $display("FAIL wr_addr cyc=%0d got=%0d exp=%0d", a, waddr10, a);
            end
            checks++;
            if (wdata10 !== exp_d) begin
                errors++;
                $display("FAIL wr_data addr=%0d got=%b exp=%b", a, wdata10, exp_d);
            end
            checks++;
            if ({busy10, done10, err10, rdy10} !== 4'b1000) begin
                errors++;
                $display("FAIL write_status cyc=%0d got=%b exp=1000", a, {busy10, done10, err10, rdy10});
            end
            @(negedge clk);
        end
    endtask

    task automatic run_req10(input logic d, input logic [9:0] k, input logic [9:0] m, input int e);
        @(negedge clk);
        checks++;
        if (rdy10 !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_req got=%b exp=1", rdy10);
        end
        v10 = 1'b1; del10 = d; key10 = k; mask10 = m; ent10 = 3'(e);
        @(negedge clk);
        v10 = 1'b0; del10 = 1'($urandom); key10 = 10'($urandom); mask10 = 10'($urandom);
        ent10 = 3'($urandom);
        if (e < 6) begin
            expect_writes10(d, k, m, e, 32);
            checks++;
            if ({busy10, done10, err10, rdy10, wen10} !== {4'b0101, 6'b0}) begin
                errors++;
                $display("FAIL fin got=%b exp=0101000000", {busy10, done10, err10, rdy10, wen10});
            end
        end else begin
            checks++;
            if ({busy10, done10, err10, rdy10, wen10} !== {4'b0111, 6'b0}) begin
                errors++;
                $display("FAIL err_fin got=%b exp=0111000000", {busy10, done10, err10, rdy10, wen10});
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({rdy10, wen10, waddr10, wdata10, busy10, done10, err10} !== {1'b1, 16'b0}) begin
            errors++;
            $display("FAIL reset10 got=%b", {rdy10, wen10, waddr10, wdata10, busy10, done10, err10});
        end
        checks++;
        if ({rdy8, wen8, waddr8, wdata8, busy8, done8, err8} !== {1'b1, 16'b0}) begin
            errors++;
            $display("FAIL reset8 got=%b", {rdy8, wen8, waddr8, wdata8, busy8, done8, err8});
        end
    endtask

    task automatic test_exact;
        run_req10(1'b0, 10'h155, 10'h3FF, 2);
    endtask

    task automatic test_dont_care;
        run_req10(1'b0, 10'h155, 10'h3E0, 2);
    endtask

    task automatic test_delete;
        run_req10(1'b1, 10'h155, 10'h3FF, 5);
    endtask

    task automatic test_error;
        run_req10(1'b0, 10'h155, 10'h3FF, 6);
        run_req10(1'b0, 10'h0AA, 10'h3FF, 7);
    endtask

    task automatic test_pad_kw8;
        logic [1:0] exp_d;
        @(negedge clk);
        v8 = 1'b1; del8 = 1'b0; key8 = 8'hA7; mask8 = 8'hFF; ent8 = 3'd3;
        @(negedge clk);
        v8 = 1'b0; key8 = 8'h00;
        for (int a = 0; a < 32; a++) begin
            exp_d = model_bits(8, 1'b0, 10'h0A7, 10'h0FF, a);
            checks++;
            if ({wen8, waddr8, wdata8} !== {6'b001000, 5'(a), exp_d}) begin
                errors++;
                $display("FAIL kw8_write addr=%0d got=%b/%0d/%b exp=001000/%0d/%b",
                         a, wen8, waddr8, wdata8, a, exp_d);
            end
            @(negedge clk);
        end
        checks++;
        if ({done8, err8, wen8} !== {2'b10, 6'b0}) begin
            errors++;
            $display("FAIL kw8_done got=%b exp=10000000", {done8, err8, wen8});
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 15; i++) begin
            run_req10(($urandom_range(0, 3) == 0), 10'($urandom), 10'($urandom),
                      int'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_back_to_back_reset;
        logic [9:0] ka, ma, kb, mb;
        ka = 10'($urandom); ma = 10'($urandom); kb = 10'($urandom); mb = 10'($urandom);
        @(negedge clk);
        v10 = 1'b1; del10 = 1'b0; key10 = ka; mask10 = ma; ent10 = 3'd1;
        @(negedge clk);
        // Request B is presented while busy; it must only be taken in FIN.
        key10 = kb; mask10 = mb; ent10 = 3'd4;
        expect_writes10(1'b0, ka, ma, 1, 32);
        checks++;
        if ({done10, err10, rdy10} !== 3'b101) begin
            errors++;
            $display("FAIL b2b_fin got=%b exp=101", {done10, err10, rdy10});
        end
        @(negedge clk);
        v10 = 1'b0;
        expect_writes10(1'b0, kb, mb, 4, 10);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({wen10, busy10, done10, rdy10} !== {6'b0, 3'b001}) begin
            errors++;
            $display("FAIL async_reset got=%b exp=000000001", {wen10, busy10, done10, rdy10});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if ({done10, rdy10, wen10} !== {2'b01, 6'b0}) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got=%b exp=01000000", i, {done10, rdy10, wen10});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v10 = 1'b0; del10 = 1'b0; key10 = '0; mask10 = '0; ent10 = '0;
        v8 = 1'b0; del8 = 1'b0; key8 = '0; mask8 = '0; ent8 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_exact();
        test_dont_care();
        test_delete();
        test_error();
        test_pad_kw8();
        test_random();
        test_back_to_back_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tcam_entry_writer.md
Name: tcam_entry_writer

Overview:
- Write-side programming engine for the FracTCAM match array.
- Takes a (key, mask, entry) update or delete request and produces the write sequence into the per-column LUTRAM match tables for that entry.
- Each LUTRAM is 2^CHUNK x 1. The AND-reduction tree later combines the per-column match bits into one match line per entry.
- Sits between the control-plane request interface and the LUTRAM write ports of all COLS x DEPTH cells.

Parameters:
- KEY_WIDTH, 30, TCAM key width in bits.
- CHUNK, 5, key bits per LUTRAM column; each column table holds 2^CHUNK addresses.
- DEPTH, 64, number of TCAM entries (match lines).
- COLS, derived = (KEY_WIDTH+CHUNK-1)/CHUNK, number of LUTRAM columns.
- ENTRY_W, derived = max(1, clog2(DEPTH)), entry index width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  request valid.
- s_ready  out  1  request accepted when s_valid && s_ready.
- s_del  in  1  1 = delete entry (never matches), 0 = program key/mask.
- s_key  in  KEY_WIDTH  key value.
- s_mask  in  KEY_WIDTH  care mask; 1 = bit compared, 0 = don't care.
- s_entry  in  ENTRY_W  target entry index.
- wr_en  out  DEPTH  one-hot entry write strobe to the LUTRAMs of that entry.
- wr_addr  out  CHUNK  LUTRAM write address, shared by all columns.
- wr_data  out  COLS  per-column write bit.
- busy  out  1  high while a request is being processed.
- done  out  1  one-cycle pulse when a request completes.
- err  out  1  valid with done; 1 = entry index >= DEPTH, nothing written.

Behaviour:
- All outputs are registered.
- Reset values: s_ready=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0.
- FSM states: IDLE, WRITE, FIN.
- IDLE:
  - s_ready=1.
  - On handshake, latch s_del, s_key, s_mask and s_entry, then clear the address counter.
  - If s_entry >= DEPTH, go to FIN with the err flag set. Otherwise go to WRITE.
  - s_ready drops in the cycle after the handshake.
- Key and mask padding: before splitting into chunks, pad the key and mask to COLS*CHUNK bits. Pad key bits are 0 and pad mask bits are 0 (don't care), so pad bits always match.
- WRITE, one LUTRAM address per cycle, cnt = 0 .. 2^CHUNK-1:
  - wr_en = onehot(entry).
  - wr_addr = cnt.
  - wr_data[c] = del ? 0 : (((cnt ^ key[c*CHUNK +: CHUNK]) & mask[c*CHUNK +: CHUNK]) == 0).
  - After cnt = 2^CHUNK-1, go to FIN.
- FIN, one cycle:
  - wr_en=0, done=1, err=latched flag, s_ready=1, busy=0.
  - A handshake in this cycle is accepted, with the same latching as IDLE.
  - Otherwise go to IDLE.
- Timing for handshake at cycle T:
  - wr_en is high on cycles T+1 .. T+2^CHUNK.
  - done is on cycle T+2^CHUNK+1.
  - The next accepted request can start writes at T+2^CHUNK+2.
- Error path: handshake at T gives done=err=1 at T+1 with wr_en=0 throughout.
- busy=1 from the cycle after accept through the last WRITE cycle.
- Inputs are ignored while s_ready=0. The request is captured at the handshake only.
- No wr_en bit other than onehot(entry) ever asserts. wr_en is all-zero outside WRITE.
- Reset mid-operation:
  - Outputs go to reset values immediately (asynchronous).
  - The FSM returns to IDLE and no done is issued.
  - The partially written entry contents are undefined; the control plane must reissue the request.
- Delete writes all 2^CHUNK addresses of every column with 0, so the entry's match line is 0 for every key.

Test Plan:
- KEY_WIDTH=10, CHUNK=5, DEPTH=6, s_key=0x155, s_mask=0x3FF, s_entry=2 -> 32 cycles with wr_en=6'b000100 and wr_addr 0..31. wr_data[0]=1 only at addr 0x15. wr_data[1]=1 only at addr 0x0A. done=1, err=0 on cycle T+33.
- Same configuration, s_mask=0x3E0 (column 0 don't care) -> wr_data[0]=1 at all 32 addresses. wr_data[1] matches only at 0x0A.
- Same configuration, s_del=1, s_entry=5 -> wr_en=6'b100000 for 32 cycles with wr_data=0. done pulses with err=0.
- Same configuration, s_entry=6 -> no wr_en activity. done=1 and err=1 on T+1. s_ready=1 on T+1.
- KEY_WIDTH=8, CHUNK=5, s_key=0xA7, s_mask=0xFF -> column 1 matches exactly at addr with addr[2:0]=3'b101, i.e. 0x05, 0x0D, 0x15, 0x1D. Column 0 matches only at 0x07.
- Back-to-back requests with s_valid held high, then rst_n pulled low at write cycle 10 of the second request -> the second request is accepted during FIN. Reset drops wr_en to 0 asynchronously, no done follows, and s_ready=1 after reset release.
